// File: rtl/shift_exec.sv
// Iterative RV64 shifter: SLL/SRL/SRA and W-variants, up to STEP bits per cycle.
// Valid/ready on both sides; one operation in flight at a time.
module shift_exec #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        word,
    input  logic [63:0] src,
    input  logic [5:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [5:0] STEP6 = 6'(STEP);

    state_t      state;
    state_t      state_nx;
    logic [63:0] work;
    logic [5:0]  rem;
    logic [1:0]  op_q;
    logic        word_q;
    logic [5:0]  eff;
    logic [5:0]  n;
    logic [31:0] fill32;
    logic        accept;

    assign eff    = word ? {1'b0, shamt[4:0]} : shamt;
    assign fill32 = (op == 2'b10 && src[31]) ? '1 : '0;
    assign n      = (rem < STEP6) ? rem : STEP6;
    assign accept = in_valid && in_ready;
    assign result = word_q ? {{32{work[31]}}, work[31:0]} : work;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    state_nx = (eff == '0 || op == 2'b11) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem == n)
                    state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // W-ops keep the 32-bit operand in the low half; the upper half
    // only feeds SRA fill, and is dropped again when forming result.
    always_ff @(posedge clk) begin
        if (rst) begin
            work   <= '0;
            rem    <= '0;
            op_q   <= '0;
            word_q <= 1'b0;
        end else if (accept) begin
            op_q   <= op;
            word_q <= word;
            rem    <= (op == 2'b11) ? '0 : eff;
            work   <= word ? {fill32, src[31:0]} : src;
        end else if (state == SHIFT) begin
            rem <= rem - n;
            unique case (op_q)
                2'b00:   work <= work << n;
                2'b01:   work <= work >> n;
                2'b10:   work <= $signed(work) >>> n;
                default: work <= work;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_exec.sv
// Bench for shift_exec: directed corner cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_shift_exec;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        word;
    logic [63:0] src;
    logic [5:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int failures = 0;

    shift_exec #(.STEP(STEP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .src(src), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                          input logic [63:0] s, input logic [5:0] sh);
        int          k;
        logic [31:0] a;
        logic [31:0] r32;
        logic [63:0] r;
        k = w ? int'(sh) % 32 : int'(sh);
        a = s[31:0];
        if (w) begin
            case (o)
                2'd0:    r32 = a << k;
                2'd1:    r32 = a >> k;
                2'd2:    r32 = $signed(a) >>> k;
                default: r32 = a;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (o)
                2'd0:    r = s << k;
                2'd1:    r = s >> k;
                2'd2:    r = $signed(s) >>> k;
                default: r = s;
            endcase
        end
        return r;
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic w,
                                     input logic [5:0] sh);
        int k;
        k = w ? int'(sh) % 32 : int'(sh);
        if (k == 0 || o == 2'd3) return 1;
        return 1 + (k + STEP - 1) / STEP;
    endfunction

    // Drive one request into IDLE, then scramble inputs so later
    // changes would show up if the DUT failed to latch them.
    task automatic start_op(input logic [1:0] o, input logic w,
                            input logic [63:0] s, input logic [5:0] sh);
        @(negedge clk);
        op = o; word = w; src = s; shamt = sh;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 2'($urandom);
        word = 1'($urandom);
        src = {$urandom, $urandom};
        shamt = 6'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        op = 2'd0; word = 1'b0; src = 64'hFFFF; shamt = 6'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b busy=%b result=%h want 0 0 0",
                     out_valid, busy, result);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  vo[7]  = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
        logic        vw[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] vs[7]  = '{64'h1, 64'h8000_0000_0000_0000,
                                64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000,
                                64'h1, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_8765_4321};
        logic [5:0]  vh[7]  = '{6'd63, 6'd4, 6'd31, 6'd31, 6'h21, 6'd0, 6'd17};
        logic [63:0] vr[7]  = '{64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000,
                                64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
                                64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_8765_4321};
        int          vl[7]  = '{17, 2, 9, 9, 2, 1, 1};
        int lat;
        for (int i = 0; i < 7; i++) begin
            start_op(vo[i], vw[i], vs[i], vh[i]);
            wait_valid(lat);
            checks++;
            if (out_valid !== 1'b1 || result !== vr[i] || lat != vl[i]) begin
                failures++;
                $display("FAIL directed_%0d: result=%h lat=%0d valid=%b want %h lat=%0d",
                         i, result, lat, out_valid, vr[i], vl[i]);
            end
            handshake();
        end
        for (int o = 0; o < 4; o++) begin
            start_op(2'(o), 1'b0, 64'h0123_4567_89AB_CDEF, 6'd0);
            wait_valid(lat);
            checks++;
            if (result !== 64'h0123_4567_89AB_CDEF || lat != 1) begin
                failures++;
                $display("FAIL shamt0_op%0d: result=%h lat=%0d want src lat=1", o, result, lat);
            end
            handshake();
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic        w;
        logic [63:0] s;
        logic [5:0]  h;
        logic [63:0] exp_r;
        int          exp_l;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            w = 1'($urandom);
            s = {$urandom, $urandom};
            h = 6'($urandom);
            exp_r = model(o, w, s, h);
            exp_l = model_lat(o, w, h);
            start_op(o, w, s, h);
            wait_valid(lat);
            checks++;
            if (out_valid !== 1'b1 || result !== exp_r || lat != exp_l) begin
                failures++;
                $display("FAIL random_%0d op=%0d w=%b src=%h sh=%0d: result=%h lat=%0d want %h lat=%0d",
                         i, o, w, s, h, result, lat, exp_r, exp_l);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        int          lat;
        bit          bad;
        start_op(2'd1, 1'b0, 64'hF000_0000_0000_0000, 6'd12);
        wait_valid(lat);
        held = model(2'd1, 1'b0, 64'hF000_0000_0000_0000, 6'd12);
        bad = 1'b0;
        in_valid = 1'b1; op = 2'd0; word = 1'b0; src = 64'h3; shamt = 6'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL backpressure_hold: result=%h valid=%b in_ready=%b want %h 1 0",
                     result, out_valid, in_ready, held);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: in_ready=%b busy=%b valid=%b want 1 0 0",
                     in_ready, busy, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src = 64'hDEAD;
        wait_valid(lat);
        checks++;
        if (result !== 64'h300 || lat != 3) begin
            failures++;
            $display("FAIL backpressure_next: result=%h lat=%0d want 300 lat=3", result, lat);
        end
        handshake();
    endtask

    task automatic test_reset_abort();
        bit late;
        start_op(2'd0, 1'b0, 64'h1, 6'd40);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 64'd0) begin
            failures++;
            $display("FAIL abort_state: valid=%b busy=%b in_ready=%b result=%h want 0 0 1 0",
                     out_valid, busy, in_ready, result);
        end
        late = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) late = 1'b1;
        end
        checks++;
        if (late) begin
            failures++;
            $display("FAIL abort_late_valid: out_valid=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
